// File: rtl/troisbriques_pkg.sv
// Shared TroisBriques definitions: FSM encoding, column indices, height width and saturating helpers.
package troisbriques_pkg;

    localparam int unsigned HEIGHT_W     = 3;
    localparam int unsigned HMAX_DEFAULT = 7;
    localparam int unsigned NCOL         = 3;
    localparam int unsigned GAUCHE       = 0;
    localparam int unsigned CENTRE       = 1;
    localparam int unsigned DROITE       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2,
        OVER  = 2'd3
    } state_e;

    typedef logic [HEIGHT_W-1:0] height_t;

    function automatic height_t inc_sat(input height_t h, input height_t hmax);
        return (h >= hmax) ? h : HEIGHT_W'(h + HEIGHT_W'(1));
    endfunction

    function automatic height_t dec_sat(input height_t h);
        return (h == '0) ? h : HEIGHT_W'(h - HEIGHT_W'(1));
    endfunction

endpackage

// File: rtl/pile_hauteurs_if.sv
// Pesanteur <-> column-height store bus; master is the game side, slave is pile_hauteurs.
interface pile_hauteurs_if #(
    parameter int unsigned SCORE_W = 8
) ();

    logic                                  pulse;
    logic                                  PlusGauche;
    logic                                  PlusCentre;
    logic                                  PlusDroite;
    logic                                  Aligne;
    logic                                  Perdu;
    logic [troisbriques_pkg::HEIGHT_W-1:0] hauteurGauche;
    logic [troisbriques_pkg::HEIGHT_W-1:0] hauteurCentre;
    logic [troisbriques_pkg::HEIGHT_W-1:0] hauteurDroite;
    logic [SCORE_W-1:0]                    score;
    logic                                  clignote;
    logic                                  fin;

    modport master (
        output pulse, PlusGauche, PlusCentre, PlusDroite, Aligne, Perdu,
        input  hauteurGauche, hauteurCentre, hauteurDroite, score, clignote, fin
    );

    modport slave (
        input  pulse, PlusGauche, PlusCentre, PlusDroite, Aligne, Perdu,
        output hauteurGauche, hauteurCentre, hauteurDroite, score, clignote, fin
    );

endinterface

// File: rtl/detect_front.sv
// 1-bit registered rising-edge detector: front is high for the cycle where x rises.
module detect_front (
    input  logic clk,
    input  logic reset,
    input  logic x_i,
    output logic front_c_o
);

    logic x_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= 1'b0;
        end else begin
            x_q <= x_i;
        end
    end

    assign front_c_o = x_i & ~x_q;

endmodule

// File: rtl/pile_hauteurs.sv
// Column heights, score and game-over state for TroisBriques.
// Optional CLEAR_BLINK_EN: blink the completed row for BLINK_N pulse fronts before removing it.
module pile_hauteurs
    import troisbriques_pkg::*;
#(
    parameter int unsigned HMAX    = HMAX_DEFAULT,
    parameter int unsigned SCORE_W = 8,
    parameter int unsigned BLINK_N = 4
) (
    input  logic           clk,
    input  logic           reset,
    pile_hauteurs_if.slave bus
);

    localparam height_t HMAX_H = HEIGHT_W'(HMAX);

    logic [NCOL-1:0] plus_raw;
    logic [NCOL-1:0] plus_front;
    logic            aligne_front;
    logic            pulse_front;

    assign plus_raw[GAUCHE] = bus.PlusGauche;
    assign plus_raw[CENTRE] = bus.PlusCentre;
    assign plus_raw[DROITE] = bus.PlusDroite;

    for (genvar i = 0; i < NCOL; i++) begin : g_plus
        detect_front u_plus (
            .clk       (clk),
            .reset     (reset),
            .x_i       (plus_raw[i]),
            .front_c_o (plus_front[i])
        );
    end

    detect_front u_aligne (
        .clk       (clk),
        .reset     (reset),
        .x_i       (bus.Aligne),
        .front_c_o (aligne_front)
    );

    detect_front u_pulse (
        .clk       (clk),
        .reset     (reset),
        .x_i       (bus.pulse),
        .front_c_o (pulse_front)
    );

    state_e                 state_q, state_d;
    height_t [NCOL-1:0]     h_q, h_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [NCOL-1:0]        pend_q, pend_d;
    logic                   fin_q, fin_d;
    logic                   at_max_c;

`ifdef CLEAR_BLINK_EN
    localparam int unsigned        BLINK_W    = (BLINK_N > 1) ? $clog2(BLINK_N) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_N - 1);

    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               clig_q, clig_d;
`else
    logic unused_pulse;
    assign unused_pulse = pulse_front ^ BLINK_N[0];
`endif

    // A full column ends the game on the following edge.
    always_comb begin
        at_max_c = 1'b0;
        for (int unsigned i = 0; i < NCOL; i++) begin
            if (h_q[i] == HMAX_H) at_max_c = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        score_d = score_q;
        pend_d  = pend_q;
        fin_d   = fin_q;
`ifdef CLEAR_BLINK_EN
        blink_d = blink_q;
        clig_d  = clig_q;
`endif
        // Loss wins over any clear or landing in the same cycle; everything freezes.
        if (state_q == OVER || bus.Perdu || at_max_c) begin
            state_d = OVER;
            fin_d   = 1'b1;
            pend_d  = '0;
`ifdef CLEAR_BLINK_EN
            blink_d = '0;
            clig_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    for (int unsigned i = 0; i < NCOL; i++) begin
                        if (plus_front[i] | pend_q[i]) h_d[i] = inc_sat(h_q[i], HMAX_H);
                    end
                    pend_d = '0;
                    if (aligne_front) begin
`ifdef CLEAR_BLINK_EN
                        state_d = WAIT;
                        blink_d = '0;
`else
                        state_d = CLEAR;
`endif
                    end
                end
`ifdef CLEAR_BLINK_EN
                WAIT: begin
                    for (int unsigned i = 0; i < NCOL; i++) begin
                        if (plus_front[i]) h_d[i] = inc_sat(h_q[i], HMAX_H);
                    end
                    if (pulse_front) begin
                        if (blink_q == BLINK_LAST) begin
                            state_d = CLEAR;
                            blink_d = '0;
                            clig_d  = 1'b0;
                        end else begin
                            blink_d = blink_q + BLINK_W'(1);
                            clig_d  = ~clig_q;
                        end
                    end
                end
`endif
                CLEAR: begin
                    for (int unsigned i = 0; i < NCOL; i++) begin
                        h_d[i] = dec_sat(h_q[i]);
                    end
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                    // Landings during the removal cycle are replayed in the next IDLE cycle.
                    pend_d  = plus_front;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            score_q <= '0;
            pend_q  <= '0;
            fin_q   <= 1'b0;
`ifdef CLEAR_BLINK_EN
            blink_q <= '0;
            clig_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            score_q <= score_d;
            pend_q  <= pend_d;
            fin_q   <= fin_d;
`ifdef CLEAR_BLINK_EN
            blink_q <= blink_d;
            clig_q  <= clig_d;
`endif
        end
    end

    assign bus.hauteurGauche = h_q[GAUCHE];
    assign bus.hauteurCentre = h_q[CENTRE];
    assign bus.hauteurDroite = h_q[DROITE];
    assign bus.score         = score_q;
    assign bus.fin           = fin_q;
`ifdef CLEAR_BLINK_EN
    assign bus.clignote      = clig_q;
`else
    assign bus.clignote      = 1'b0;
`endif

endmodule

// File: tb/tb_pile_hauteurs.sv
// Directed bench for pile_hauteurs: landings, clears, score saturation, game over and reset.
module tb_pile_hauteurs;

    localparam int unsigned SCORE_W = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    pile_hauteurs_if #(.SCORE_W(SCORE_W)) ifc ();

    pile_hauteurs #(
        .HMAX    (7),
        .SCORE_W (SCORE_W),
        .BLINK_N (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    logic [8:0] hts;
    assign hts = {ifc.hauteurGauche, ifc.hauteurCentre, ifc.hauteurDroite};

    task automatic clear_inputs();
        ifc.pulse = 1'b0; ifc.PlusGauche = 1'b0; ifc.PlusCentre = 1'b0;
        ifc.PlusDroite = 1'b0; ifc.Aligne = 1'b0; ifc.Perdu = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic bricks(input logic [2:0] cols);
        ifc.PlusGauche = cols[0]; ifc.PlusCentre = cols[1]; ifc.PlusDroite = cols[2];
        @(negedge clk);
        ifc.PlusGauche = 1'b0; ifc.PlusCentre = 1'b0; ifc.PlusDroite = 1'b0;
        @(negedge clk);
    endtask

    task automatic aligne();
        ifc.Aligne = 1'b1;
        @(negedge clk);
        ifc.Aligne = 1'b0;
    endtask

    // Leaves the DUT in the removal cycle; the caller's next edge performs it.
    task automatic to_clear();
`ifdef CLEAR_BLINK_EN
        for (int k = 0; k < 4; k++) begin
            logic exp_c;
            exp_c = (k == 3) ? 1'b0 : ((k % 2) == 0);
            ifc.pulse = 1'b1;
            @(negedge clk);
            ifc.pulse = 1'b0;
            n_cmp++;
            if (ifc.clignote !== exp_c) begin
                n_err++;
                $display("FAIL blink_toggle[%0d]: got %b expected %b", k, ifc.clignote, exp_c);
            end
            if (k < 3) @(negedge clk);
        end
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({hts, ifc.score, ifc.clignote, ifc.fin} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got h=%o s=%0d c=%b f=%b expected all 0", hts, ifc.score, ifc.clignote, ifc.fin);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({hts, ifc.score, ifc.clignote, ifc.fin} !== '0) begin
            n_err++;
            $display("FAIL reset_release: got h=%o s=%0d c=%b f=%b expected all 0", hts, ifc.score, ifc.clignote, ifc.fin);
        end
    endtask

    task automatic test_increment();
        do_reset();
        bricks(3'b001);
        n_cmp++;
        if (hts !== 9'o100) begin n_err++; $display("FAIL inc_first: got %o expected 100", hts); end
        bricks(3'b001);
        bricks(3'b010);
        repeat (3) bricks(3'b100);
        n_cmp++;
        if (hts !== 9'o213) begin n_err++; $display("FAIL inc_213: got %o expected 213", hts); end
        n_cmp++;
        if (ifc.score !== 8'd0) begin n_err++; $display("FAIL inc_score: got %0d expected 0", ifc.score); end
        bricks(3'b111);
        n_cmp++;
        if (hts !== 9'o324) begin n_err++; $display("FAIL inc_simultaneous: got %o expected 324", hts); end
    endtask

    task automatic test_level_held();
        do_reset();
        ifc.PlusCentre = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (hts !== 9'o010) begin n_err++; $display("FAIL held_first: got %o expected 010", hts); end
        repeat (9) @(negedge clk);
        ifc.PlusCentre = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hts !== 9'o010) begin n_err++; $display("FAIL held_once: got %o expected 010", hts); end
    endtask

    task automatic test_clear();
        do_reset();
        bricks(3'b111);
        aligne();
        to_clear();
        n_cmp++;
        if (hts !== 9'o111) begin n_err++; $display("FAIL clear_before: got %o expected 111", hts); end
        @(negedge clk);
        n_cmp++;
        if (hts !== 9'o000 || ifc.score !== 8'd1) begin
            n_err++; $display("FAIL clear_done: got h=%o s=%0d expected h=000 s=1", hts, ifc.score);
        end
        aligne();
        to_clear();
        @(negedge clk);
        n_cmp++;
        if (hts !== 9'o000 || ifc.score !== 8'd2) begin
            n_err++; $display("FAIL clear_at_zero: got h=%o s=%0d expected h=000 s=2", hts, ifc.score);
        end
    endtask

    task automatic test_plus_with_aligne();
        do_reset();
        bricks(3'b111);
        bricks(3'b111);
        ifc.PlusDroite = 1'b1;
        ifc.Aligne     = 1'b1;
        @(negedge clk);
        ifc.PlusDroite = 1'b0;
        ifc.Aligne     = 1'b0;
        n_cmp++;
        if (hts !== 9'o223) begin n_err++; $display("FAIL plus_aligne_inc: got %o expected 223", hts); end
        to_clear();
        @(negedge clk);
        n_cmp++;
        if (hts !== 9'o112 || ifc.score !== 8'd1) begin
            n_err++; $display("FAIL plus_aligne_clear: got h=%o s=%0d expected h=112 s=1", hts, ifc.score);
        end
    endtask

    task automatic test_plus_during_clear();
        do_reset();
        bricks(3'b111);
        aligne();
        to_clear();
        ifc.PlusGauche = 1'b1;
        @(negedge clk);
        ifc.PlusGauche = 1'b0;
        n_cmp++;
        if (hts !== 9'o000 || ifc.score !== 8'd1) begin
            n_err++; $display("FAIL held_plus_clear: got h=%o s=%0d expected h=000 s=1", hts, ifc.score);
        end
        @(negedge clk);
        n_cmp++;
        if (hts !== 9'o100) begin n_err++; $display("FAIL held_plus_replay: got %o expected 100", hts); end
    endtask

    task automatic test_score_sat();
        do_reset();
        for (int k = 0; k < 257; k++) begin
            aligne();
            to_clear();
            @(negedge clk);
            if (k == 254) begin
                n_cmp++;
                if (ifc.score !== 8'd255) begin
                    n_err++; $display("FAIL score_255: got %0d expected 255", ifc.score);
                end
            end
        end
        n_cmp++;
        if (ifc.score !== 8'd255 || ifc.fin !== 1'b0) begin
            n_err++; $display("FAIL score_sat: got s=%0d f=%b expected s=255 f=0", ifc.score, ifc.fin);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        repeat (6) bricks(3'b001);
        ifc.PlusGauche = 1'b1;
        @(negedge clk);
        ifc.PlusGauche = 1'b0;
        n_cmp++;
        if (hts !== 9'o700 || ifc.fin !== 1'b0) begin
            n_err++; $display("FAIL over_reach: got h=%o f=%b expected h=700 f=0", hts, ifc.fin);
        end
        @(negedge clk);
        n_cmp++;
        if (ifc.fin !== 1'b1) begin n_err++; $display("FAIL over_fin: got %b expected 1", ifc.fin); end
        bricks(3'b010);
        aligne();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (hts !== 9'o700 || ifc.score !== 8'd0 || ifc.fin !== 1'b1 || ifc.clignote !== 1'b0) begin
            n_err++;
            $display("FAIL over_frozen: got h=%o s=%0d f=%b c=%b expected h=700 s=0 f=1 c=0", hts, ifc.score, ifc.fin, ifc.clignote);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({hts, ifc.score, ifc.clignote, ifc.fin} !== '0) begin
            n_err++;
            $display("FAIL over_async_reset: got h=%o s=%0d c=%b f=%b expected all 0", hts, ifc.score, ifc.clignote, ifc.fin);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_perdu();
        do_reset();
        bricks(3'b111);
        aligne();
`ifdef CLEAR_BLINK_EN
        ifc.pulse = 1'b1;
        @(negedge clk);
        ifc.pulse = 1'b0;
        n_cmp++;
        if (ifc.clignote !== 1'b1) begin n_err++; $display("FAIL perdu_blink_on: got %b expected 1", ifc.clignote); end
`endif
        ifc.Perdu = 1'b1;
        @(negedge clk);
        ifc.Perdu = 1'b0;
        n_cmp++;
        if (hts !== 9'o111 || ifc.score !== 8'd0 || ifc.fin !== 1'b1 || ifc.clignote !== 1'b0) begin
            n_err++;
            $display("FAIL perdu_over: got h=%o s=%0d f=%b c=%b expected h=111 s=0 f=1 c=0", hts, ifc.score, ifc.fin, ifc.clignote);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (hts !== 9'o111 || ifc.fin !== 1'b1) begin
            n_err++; $display("FAIL perdu_sticky: got h=%o f=%b expected h=111 f=1", hts, ifc.fin);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_reset();
        bricks(3'b111);
        aligne();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (hts !== 9'o000 || ifc.score !== 8'd0 || ifc.fin !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_clear: got h=%o s=%0d f=%b expected h=000 s=0 f=0", hts, ifc.score, ifc.fin);
        end
        bricks(3'b001);
        n_cmp++;
        if (hts !== 9'o100) begin n_err++; $display("FAIL reset_then_idle: got %o expected 100", hts); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_level_held();
        test_clear();
        test_plus_with_aligne();
        test_plus_during_clear();
        test_score_sat();
        test_game_over();
        test_perdu();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
